io_input_handshake: RTL and testbench

//   Upstream stage of the 7-segment IO block: synchronises the 10 slide switches and
//   the Enter key, debounces Enter, and runs the IN-instruction handshake with the

---
 rtl/io_input_handshake.sv | 83 ++++++++
 tb/tb_io_input_handshake.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/io_input_handshake.sv
// io_input_handshake: synchronises switches and Enter, debounces Enter and runs the
// IN-instruction stall/capture handshake with the core.
module io_input_handshake #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_W            = 10,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic [SW_W-1:0]   sw,
    input  logic              Enter,
    output logic              stall,
    output logic              in_done,
    output logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] live_data,
    output logic              in_active
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_RELEASE, WAIT_PRESS, DONE} state_e;

    state_e            state_q, state_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
    logic              en_meta_q, en_sync_q;
    logic              enter_db_q, enter_db_d, enter_prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              mismatch, hit, press;

    // The counter only ever reaches DEBOUNCE_CYCLES-1; the next mismatched cycle commits.
    always_comb begin
        mismatch   = en_sync_q != enter_db_q;
        hit        = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d      = (!mismatch || hit) ? '0 : cnt_q + CW'(1);
        enter_db_d = (mismatch && hit) ? en_sync_q : enter_db_q;
        press      = enter_db_q & ~enter_prev_q;
        in_data_d  = (state_q == WAIT_PRESS && in_req && press) ? DATA_W'(sw_sync_q) : in_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            en_meta_q    <= 1'b0;
            en_sync_q    <= 1'b0;
            enter_db_q   <= 1'b0;
            enter_prev_q <= 1'b0;
            cnt_q        <= '0;
            in_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            sw_meta_q    <= sw;
            sw_sync_q    <= sw_meta_q;
            en_meta_q    <= Enter;
            en_sync_q    <= en_meta_q;
            enter_db_q   <= enter_db_d;
            enter_prev_q <= enter_db_q;
            cnt_q        <= cnt_d;
            in_data_q    <= in_data_d;
        end
    end

    // A dropped in_req (flush) takes priority over a press in the wait states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = !in_req ? IDLE : enter_db_q ? WAIT_RELEASE : WAIT_PRESS;
            WAIT_RELEASE: state_d = !in_req ? IDLE : !enter_db_q ? WAIT_PRESS : WAIT_RELEASE;
            WAIT_PRESS:   state_d = !in_req ? IDLE : press ? DONE : WAIT_PRESS;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        in_done   = state_q == DONE;
        in_active = state_q == WAIT_RELEASE || state_q == WAIT_PRESS;
        stall     = in_req && state_q != DONE;
        in_data   = in_data_q;
        live_data = DATA_W'(sw_sync_q);
    end
endmodule

// File: tb/tb_io_input_handshake.sv
// tb_io_input_handshake: directed stimulus with a scoreboard queue of expected captures
// checked by an independent monitor whenever in_done pulses.
module tb_io_input_handshake;
    logic        clk = 1'b0;
    logic        reset, in_req, Enter;
    logic [9:0]  sw;
    logic        stall, in_done, in_active;
    logic [31:0] in_data, live_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    io_input_handshake #(.DEBOUNCE_CYCLES(4), .SW_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .sw(sw), .Enter(Enter),
        .stall(stall), .in_done(in_done), .in_data(in_data),
        .live_data(live_data), .in_active(in_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every in_done pulse must match the oldest expected capture.
    always begin
        @(posedge clk);
        #1;
        if (in_done === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_in_done", 32'd1, 32'd0);
            else chk("in_data_at_done", in_data, exp_q.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for in_done, requiring stall high before it and low during it.
    task automatic wait_done(input string name, input int exp_cyc);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (in_done === 1'b1) begin
                chk({name, "_latency"}, i, exp_cyc);
                chk({name, "_stall_at_done"}, {31'd0, stall}, 32'd0);
                return;
            end
            chk({name, "_stall_wait"}, {31'd0, stall}, 32'd1);
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_req = 1'b0; Enter = 1'b0; sw = '0;
        cycles(2);
        reset = 1'b0;
        cycles(1);
        chk("rst_in_data", in_data, 32'd0);
        chk("rst_live", live_data, 32'd0);
        chk("rst_active", {31'd0, in_active}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // Basic IN: capture 5 after debounced press.
        sw = 10'h005; in_req = 1'b1;
        cycles(3);
        chk("wait_active", {31'd0, in_active}, 32'd1);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        exp_q.push_back(32'd5);
        Enter = 1'b1;
        wait_done("in1", 7);
        cycles(1);
        chk("after_done", {31'd0, in_done}, 32'd0);

        // Back-to-back IN with Enter still held: no capture until release+press.
        sw = 10'h3FF;
        cycles(12);
        chk("held_stall", {31'd0, stall}, 32'd1);
        chk("held_data", in_data, 32'd5);
        Enter = 1'b0;
        cycles(12);
        chk("released_stall", {31'd0, stall}, 32'd1);
        exp_q.push_back(32'd1023);
        Enter = 1'b1;
        wait_done("in2", 7);
        in_req = 1'b0;
        Enter = 1'b0;
        cycles(12);
        chk("idle_active", {31'd0, in_active}, 32'd0);

        // Glitch of 3 cycles in WAIT_PRESS is rejected.
        sw = 10'h155; in_req = 1'b1;
        cycles(3);
        Enter = 1'b1;
        cycles(3);
        Enter = 1'b0;
        cycles(12);
        chk("glitch_stall", {31'd0, stall}, 32'd1);
        chk("glitch_data", in_data, 32'd1023);
        // Exactly 4 stable cycles is accepted.
        exp_q.push_back(32'h155);
        Enter = 1'b1;
        cycles(4);
        Enter = 1'b0;
        wait_done("in3", 3);
        in_req = 1'b0;
        cycles(12);

        // Flush before press: no capture, data kept.
        in_req = 1'b1;
        sw = 10'h0F0;
        cycles(4);
        in_req = 1'b0;
        cycles(1);
        chk("flush_active", {31'd0, in_active}, 32'd0);
        Enter = 1'b1;
        cycles(12);
        chk("flush_data", in_data, 32'h155);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        Enter = 1'b0;
        cycles(12);

        // Reset while waiting for press.
        in_req = 1'b1;
        cycles(4);
        chk("pre_rst_active", {31'd0, in_active}, 32'd1);
        reset = 1'b1;
        cycles(1);
        chk("mid_rst_data", in_data, 32'd0);
        chk("mid_rst_done", {31'd0, in_done}, 32'd0);
        chk("mid_rst_active", {31'd0, in_active}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        in_req = 1'b0;
        sw = 10'h000;
        cycles(4);

        // Live preview follows switches after two synchroniser stages.
        sw = 10'h02A;
        cycles(1);
        chk("live_1cyc", live_data, 32'd0);
        cycles(1);
        chk("live_2cyc", live_data, 32'd42);
        chk("live_in_data", in_data, 32'd0);

        cycles(2);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
